timers_tooth_sync: RTL and testbench

//  Downstream consumer of the timer-2 capture stage. Takes each captured tooth period
//  (ACRH:ACRM:ACRL) and the capture strobe, and detects the missing-tooth gap of the crank

---
 rtl/timers_tooth_sync.sv | 199 +++++++++++++++++++
 tb/tb_timers_tooth_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/timers_tooth_sync.sv
// Crank missing-tooth synchroniser: consumes timer-2 captured periods and tracks tooth/rev/sync.
// Optional stall timeout is enabled with the TIMERS_TSYNC_TIMEOUT_EN macro.
module timers_tooth_sync #(
   parameter int PERIOD_W = 24,
   parameter int TOOTH_W  = 8
`ifdef TIMERS_TSYNC_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 2**20
`endif
) (
   input  logic                timers_tsync_clock_i,
   input  logic                timers_tsync_reset_i_b,
   input  logic                timers_tsync_en_i,
   input  logic                timers_tsync_cap_i,
   input  logic [PERIOD_W-1:0] timers_tsync_period_i,
   input  logic [TOOTH_W-1:0]  timers_tsync_teeth_i,
   input  logic                timers_tsync_ratio_i,
   input  logic                timers_tsync_flag_clr_i,
   output logic [TOOTH_W-1:0]  timers_tsync_tooth_o,
   output logic [7:0]          timers_tsync_rev_o,
   output logic                timers_tsync_sync_o,
   output logic                timers_tsync_err_o,
   output logic                timers_tsync_int_o,
   output logic [1:0]          timers_tsync_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_VERIFY = 2'd2,
      ST_SYNC   = 2'd3
   } state_t;

   state_t                state_q;
   logic [TOOTH_W-1:0]    tooth_q;
   logic [7:0]            rev_q;
   logic                  sync_q;
   logic                  err_q;
   logic                  int_q;
   logic [PERIOD_W-1:0]   prev_q;
   logic                  prev_valid_q;

   logic                  accept;
   logic [PERIOD_W:0]     thr;
   logic                  is_gap;
   logic [TOOTH_W-1:0]    teeth_last;
   logic                  teeth_ok;
   logic                  at_last;
   logic                  past_last;
   logic [TOOTH_W-1:0]    tooth_inc;
   logic                  decide;
   logic                  timeout;
   logic                  err_set_d;
   logic                  int_set_d;

   assign accept     = timers_tsync_cap_i && (timers_tsync_period_i != '0);
   // 25-bit threshold so 2*prev never overflows the compare
   assign thr        = timers_tsync_ratio_i ?
                       ({1'b0, prev_q} + {2'b00, prev_q[PERIOD_W-1:1]}) :
                       {prev_q, 1'b0};
   assign is_gap     = {1'b0, timers_tsync_period_i} > thr;
   assign teeth_last = timers_tsync_teeth_i - TOOTH_W'(1);
   assign teeth_ok   = timers_tsync_teeth_i >= TOOTH_W'(2);
   assign at_last    = tooth_q == teeth_last;
   assign past_last  = tooth_q >= teeth_last;
   assign tooth_inc  = (&tooth_q) ? tooth_q : tooth_q + TOOTH_W'(1);
   assign decide     = timers_tsync_en_i && (state_q != ST_IDLE) && accept && prev_valid_q;

`ifdef TIMERS_TSYNC_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYC);
   logic [STALL_W-1:0] stall_q;
   logic               stall_run;

   assign stall_run = (state_q == ST_VERIFY) || (state_q == ST_SYNC);
   assign timeout   = timers_tsync_en_i && stall_run && !timers_tsync_cap_i &&
                      (stall_q == STALL_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge timers_tsync_clock_i or negedge timers_tsync_reset_i_b) begin
      if (!timers_tsync_reset_i_b) begin
         stall_q <= '0;
      end else if (timers_tsync_cap_i || !stall_run) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Flag set conditions; set wins over a same-cycle clear in the register below
   always_comb begin
      err_set_d = 1'b0;
      int_set_d = 1'b0;
      if (timeout) begin
         err_set_d = 1'b1;
         int_set_d = 1'b1;
      end else if (decide) begin
         case (state_q)
            ST_VERIFY: begin
               if (is_gap && at_last && teeth_ok) int_set_d = 1'b1;
            end
            ST_SYNC: begin
               if (is_gap) begin
                  int_set_d = 1'b1;
                  if (!at_last) err_set_d = 1'b1;
               end else if (past_last) begin
                  int_set_d = 1'b1;
                  err_set_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge timers_tsync_clock_i or negedge timers_tsync_reset_i_b) begin
      if (!timers_tsync_reset_i_b) begin
         state_q      <= ST_IDLE;
         tooth_q      <= '0;
         rev_q        <= '0;
         sync_q       <= 1'b0;
         err_q        <= 1'b0;
         int_q        <= 1'b0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
      end else begin
         err_q <= (err_q & ~timers_tsync_flag_clr_i) | err_set_d;
         int_q <= (int_q & ~timers_tsync_flag_clr_i) | int_set_d;
         if (!timers_tsync_en_i) begin
            state_q      <= ST_IDLE;
            tooth_q      <= '0;
            sync_q       <= 1'b0;
            prev_valid_q <= 1'b0;
         end else if (state_q == ST_IDLE) begin
            state_q <= ST_SEARCH;
         end else if (timeout) begin
            state_q      <= ST_SEARCH;
            tooth_q      <= '0;
            sync_q       <= 1'b0;
            prev_valid_q <= 1'b0;
         end else if (accept) begin
            prev_q       <= timers_tsync_period_i;
            prev_valid_q <= 1'b1;
            if (prev_valid_q) begin
               case (state_q)
                  ST_SEARCH: begin
                     if (is_gap) begin
                        state_q <= ST_VERIFY;
                        tooth_q <= '0;
                     end else begin
                        tooth_q <= tooth_inc;
                     end
                  end
                  ST_VERIFY: begin
                     if (is_gap) begin
                        tooth_q <= '0;
                        if (at_last && teeth_ok) begin
                           state_q <= ST_SYNC;
                           rev_q   <= rev_q + 8'd1;
                           sync_q  <= 1'b1;
                        end
                     end else begin
                        tooth_q <= tooth_inc;
                     end
                  end
                  ST_SYNC: begin
                     if (is_gap) begin
                        tooth_q <= '0;
                        if (at_last) begin
                           rev_q <= rev_q + 8'd1;
                        end else begin
                           state_q <= ST_VERIFY;
                           sync_q  <= 1'b0;
                        end
                     end else if (past_last) begin
                        // Gap missed: restart the search from scratch
                        state_q      <= ST_SEARCH;
                        tooth_q      <= '0;
                        sync_q       <= 1'b0;
                        prev_valid_q <= 1'b0;
                     end else begin
                        tooth_q <= tooth_inc;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign timers_tsync_tooth_o = tooth_q;
   assign timers_tsync_rev_o   = rev_q;
   assign timers_tsync_sync_o  = sync_q;
   assign timers_tsync_err_o   = err_q;
   assign timers_tsync_int_o   = int_q;
   assign timers_tsync_state_o = state_q;

endmodule

// File: tb/tb_timers_tooth_sync.sv
// Directed scoreboard bench for timers_tooth_sync (default build, 60-2 wheel).
module tb_timers_tooth_sync;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        cap = 1'b0;
   logic [23:0] period = '0;
   logic [7:0]  teeth = 8'd58;
   logic        ratio = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  tooth;
   logic [7:0]  rev;
   logic        sync;
   logic        err;
   logic        intf;
   logic [1:0]  state;

   localparam logic [1:0] IDLE = 2'd0, SEARCH = 2'd1, VERIFY = 2'd2, SYNC = 2'd3;
   localparam logic [20:0] MASK_ALL = 21'h1FFFFF;
   localparam logic [20:0] MASK_NOTOOTH = 21'h001FFF;

   timers_tooth_sync dut (
      .timers_tsync_clock_i    (clk),
      .timers_tsync_reset_i_b  (rst_n),
      .timers_tsync_en_i       (en),
      .timers_tsync_cap_i      (cap),
      .timers_tsync_period_i   (period),
      .timers_tsync_teeth_i    (teeth),
      .timers_tsync_ratio_i    (ratio),
      .timers_tsync_flag_clr_i (clr),
      .timers_tsync_tooth_o    (tooth),
      .timers_tsync_rev_o      (rev),
      .timers_tsync_sync_o     (sync),
      .timers_tsync_err_o      (err),
      .timers_tsync_int_o      (intf),
      .timers_tsync_state_o    (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [20:0] exp_q[$];
   logic [20:0] msk_q[$];

   function automatic logic [20:0] pk(input logic [7:0] t, input logic [7:0] r,
                                      input logic s, input logic e, input logic i,
                                      input logic [1:0] st);
      return {t, r, s, e, i, st};
   endfunction

   task automatic push_exp(input logic [20:0] v, input logic [20:0] m);
      exp_q.push_back(v);
      msk_q.push_back(m);
   endtask

   task automatic chk(input string tag);
      logic [20:0] obs, e, m;
      obs = {tooth, rev, sync, err, intf, state};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
      end else begin
         e = exp_q.pop_front();
         m = msk_q.pop_front();
         assert ((obs & m) === (e & m)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs & m, e & m);
         end
      end
   endtask

   task automatic step(input logic [23:0] p, input logic [7:0] t, input logic [7:0] r,
                       input logic s, input logic e, input logic i, input logic [1:0] st,
                       input logic mask_tooth, input string tag);
      push_exp(pk(t, r, s, e, i, st), mask_tooth ? MASK_NOTOOTH : MASK_ALL);
      cap = 1'b1;
      period = p;
      @(posedge clk);
      #1;
      cap = 1'b0;
      chk(tag);
   endtask

   task automatic normals(input int n, input int t0, input logic [7:0] r,
                          input logic s, input logic e, input logic i,
                          input logic [1:0] st, input string tag);
      for (int k = 0; k < n; k++) begin
         step(24'd1000, 8'(t0 + k), r, s, e, i, st, 1'b0, tag);
      end
   endtask

   task automatic pulse_clr(input logic [7:0] t, input logic [7:0] r, input logic s,
                            input logic [1:0] st, input logic mask_tooth, input string tag);
      push_exp(pk(t, r, s, 1'b0, 1'b0, st), mask_tooth ? MASK_NOTOOTH : MASK_ALL);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk(tag);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      push_exp(pk(0, 0, 0, 0, 0, IDLE), MASK_ALL);
      chk("reset");
      rst_n = 1'b1;
      en = 1'b1;
      @(posedge clk);
      #1;
      push_exp(pk(0, 0, 0, 0, 0, SEARCH), MASK_ALL);
      chk("en_search");

      // Acquisition and three revolutions
      step(24'd1000, 0, 0, 0, 0, 0, SEARCH, 1'b0, "first_strobe");
      normals(10, 1, 0, 0, 0, 0, SEARCH, "search_norm");
      step(24'd3000, 0, 0, 0, 0, 0, VERIFY, 1'b0, "gap1_verify");
      normals(57, 1, 0, 0, 0, 0, VERIFY, "verify_norm");
      step(24'd3000, 0, 1, 1, 0, 1, SYNC, 1'b0, "sync_entry");
      normals(57, 1, 1, 1, 0, 1, SYNC, "rev1_norm");
      step(24'd3000, 0, 2, 1, 0, 1, SYNC, 1'b0, "rev2_gap");
      normals(57, 1, 2, 1, 0, 1, SYNC, "rev2_norm");
      step(24'd3000, 0, 3, 1, 0, 1, SYNC, 1'b0, "rev3_gap");

      // Missed gap
      pulse_clr(0, 3, 1, SYNC, 1'b0, "clr_a");
      normals(57, 1, 3, 1, 0, 0, SYNC, "rev3_norm");
      step(24'd1000, 0, 3, 0, 1, 1, SEARCH, 1'b1, "missed_gap");
      pulse_clr(0, 3, 0, SEARCH, 1'b1, "clr_after_miss");
      step(24'd1000, 0, 3, 0, 0, 0, SEARCH, 1'b1, "search_a");
      step(24'd1000, 0, 3, 0, 0, 0, SEARCH, 1'b1, "search_b");
      step(24'd3000, 0, 3, 0, 0, 0, VERIFY, 1'b0, "regap");
      normals(57, 1, 3, 0, 0, 0, VERIFY, "reverify_norm");
      step(24'd3000, 0, 4, 1, 0, 1, SYNC, 1'b0, "resync");

      // Early gap at tooth 20
      pulse_clr(0, 4, 1, SYNC, 1'b0, "clr_b");
      normals(20, 1, 4, 1, 0, 0, SYNC, "pre_early");
      step(24'd3000, 0, 4, 0, 1, 1, VERIFY, 1'b0, "early_gap");
      normals(57, 1, 4, 0, 1, 1, VERIFY, "clean_norm");
      step(24'd3000, 0, 5, 1, 1, 1, SYNC, 1'b0, "resync2");
      pulse_clr(0, 5, 1, SYNC, 1'b0, "clr_c");

      // Ratio thresholds and same-cycle set/clear
      ratio = 1'b1;
      step(24'd1000, 1, 5, 1, 0, 0, SYNC, 1'b0, "r1_norm");
      step(24'd1600, 0, 5, 0, 1, 1, VERIFY, 1'b0, "r1_gap_1600");
      ratio = 1'b0;
      step(24'd1000, 1, 5, 0, 1, 1, VERIFY, 1'b0, "r0_norm");
      step(24'd1600, 2, 5, 0, 1, 1, VERIFY, 1'b0, "r0_not_gap_1600");
      step(24'd1000, 3, 5, 0, 1, 1, VERIFY, 1'b0, "r0_norm_b");
      step(24'd2000, 4, 5, 0, 1, 1, VERIFY, 1'b0, "r0_equal_2x");
      normals(53, 5, 5, 0, 1, 1, VERIFY, "to_last");
      push_exp(pk(0, 6, 1, 0, 1, SYNC), MASK_ALL);
      cap = 1'b1;
      period = 24'd2001;
      clr = 1'b1;
      @(posedge clk);
      #1;
      cap = 1'b0;
      clr = 1'b0;
      chk("gap_2001_with_clr");

      // Zero period, enable drop, async reset
      normals(5, 1, 6, 1, 0, 1, SYNC, "pre_zero");
      step(24'd0, 5, 6, 1, 0, 1, SYNC, 1'b0, "zero_period");
      step(24'd1000, 6, 6, 1, 0, 1, SYNC, 1'b0, "after_zero");
      en = 1'b0;
      @(posedge clk);
      #1;
      push_exp(pk(0, 6, 0, 0, 1, IDLE), MASK_ALL);
      chk("en_drop");
      en = 1'b1;
      @(posedge clk);
      #1;
      push_exp(pk(0, 6, 0, 0, 1, SEARCH), MASK_ALL);
      chk("reenable");
      step(24'd1000, 0, 6, 0, 0, 1, SEARCH, 1'b0, "re_first");
      step(24'd1000, 1, 6, 0, 0, 1, SEARCH, 1'b0, "re_norm_a");
      step(24'd1000, 2, 6, 0, 0, 1, SEARCH, 1'b0, "re_norm_b");
      rst_n = 1'b0;
      #2;
      push_exp(pk(0, 0, 0, 0, 0, IDLE), MASK_ALL);
      chk("async_reset");
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
